// File: rtl/project_req_pkg.sv
// Shared types and constants for the request-FIFO drain path.
package project_req_pkg;

  localparam int REQ_WIDTH  = 21;
  localparam int STAT_WIDTH = 32;

  // Occupancy of the two-entry output buffer.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } drain_state_t;

endpackage

// File: rtl/project_req_skid2.sv
// Two-slot output buffer with occupancy FSM.
// Slot0 is the head and is the registered output word; slot1 is the skid slot
// that absorbs the one extra entry popped in the cycle back-pressure arrives.
// `space` comes only from state, so the upstream pop decision never sees the
// downstream ready signal.
module project_req_skid2
  import project_req_pkg::*;
#(
  parameter int WIDTH = REQ_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             space
);

  drain_state_t     state;
  logic [WIDTH-1:0] slot1;
  logic             xfer;

  assign xfer  = valid & pop;
  assign space = (state != TWO);

  // Occupancy FSM with slot writes; valid and head data are registered here.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= EMPTY;
      valid <= 1'b0;
      data  <= '0;
      slot1 <= '0;
    end else begin
      case (state)
        EMPTY: begin
          if (push) begin
            data  <= push_data;
            valid <= 1'b1;
            state <= ONE;
          end
        end
        ONE: begin
          if (push && xfer) begin
            // Head leaves and the new entry replaces it in the same cycle.
            data <= push_data;
          end else if (push) begin
            slot1 <= push_data;
            state <= TWO;
          end else if (xfer) begin
            valid <= 1'b0;
            state <= EMPTY;
          end
        end
        TWO: begin
          // No push can arrive here because space is low.
          if (xfer) begin
            data  <= slot1;
            state <= ONE;
          end
        end
        default: begin
          valid <= 1'b0;
          state <= EMPTY;
        end
      endcase
    end
  end

endmodule

// File: rtl/project_req_drain.sv
// Read-side drain for the request FIFO.
// Pops the FIFO only when it is non-empty, the block is enabled and the
// output buffer has room; buffered words are presented over valid/ready.
// Optional statistics counters are built when PROJECT_REQ_DRAIN_STATS_EN
// is defined.
module project_req_drain
  import project_req_pkg::*;
#(
  parameter int WIDTH = REQ_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic                  fifo_empty,
  input  logic [WIDTH-1:0]      fifo_data,
  output logic                  fifo_read,
  output logic                  req_valid,
  output logic [WIDTH-1:0]      req_data,
  input  logic                  req_ready
`ifdef PROJECT_REQ_DRAIN_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] pop_count,
  output logic [STAT_WIDTH-1:0] stall_count
`endif
);

  logic space;

  // The FIFO tail advances on every read strobe, so the strobe must never
  // fire while the FIFO is empty, and it is held low throughout reset.
  assign fifo_read = reset & enable & ~fifo_empty & space;

  project_req_skid2 #(
    .WIDTH(WIDTH)
  ) u_skid2 (
    .clk      (clk),
    .reset    (reset),
    .push     (fifo_read),
    .push_data(fifo_data),
    .pop      (req_ready),
    .valid    (req_valid),
    .data     (req_data),
    .space    (space)
  );

`ifdef PROJECT_REQ_DRAIN_STATS_EN
  // Pop and downstream-stall counters, wrapping modulo 2^32.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pop_count   <= '0;
      stall_count <= '0;
    end else begin
      if (fifo_read) begin
        pop_count <= pop_count + STAT_WIDTH'(1);
      end
      if (req_valid && !req_ready) begin
        stall_count <= stall_count + STAT_WIDTH'(1);
      end
    end
  end
`endif

endmodule

// File: tb/tb_project_req_drain.sv
// Testbench for project_req_drain: FIFO modelled as a queue, the output
// buffer modelled as a queue of popped-but-not-yet-accepted words.
module tb_project_req_drain;
  import project_req_pkg::*;

  localparam int W = REQ_WIDTH;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b0;
  logic         fifo_empty = 1'b1;
  logic [W-1:0] fifo_data = '0;
  logic         req_ready = 1'b0;
  logic         fifo_read;
  logic         req_valid;
  logic [W-1:0] req_data;
`ifdef PROJECT_REQ_DRAIN_STATS_EN
  logic [31:0]  pop_count;
  logic [31:0]  stall_count;
`endif

  project_req_drain #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .fifo_empty (fifo_empty),
    .fifo_data  (fifo_data),
    .fifo_read  (fifo_read),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready)
`ifdef PROJECT_REQ_DRAIN_STATS_EN
    ,
    .pop_count  (pop_count),
    .stall_count(stall_count)
`endif
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int dut_pops = 0;
  int xfers = 0;
  int underflow = 0;
  int pushed = 0;
  logic [31:0] exp_pop_cnt = '0;
  logic [31:0] exp_stalls = '0;
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] buf_q[$];
  int pop_cyc[$];
  int xfer_cyc[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic fifo_sync();
    fifo_empty = (fifo_q.size() == 0);
    fifo_data  = fifo_empty ? '0 : fifo_q[0];
  endtask

  task automatic push_rand(input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(W'($urandom));
      pushed++;
    end
    fifo_sync();
  endtask

  // One clock: check outputs against the model mid-cycle, then advance it.
  task automatic tick();
    logic exp_rd;
    logic exp_xf;
    @(negedge clk);
    exp_rd = reset && enable && !fifo_empty && (buf_q.size() < 2);
    exp_xf = reset && (buf_q.size() != 0) && req_ready;
    chk("fifo_read", 32'(fifo_read), 32'(exp_rd));
    chk("req_valid", 32'(req_valid), 32'(buf_q.size() != 0));
    if (buf_q.size() != 0) chk("req_data", 32'(req_data), 32'(buf_q[0]));
    if (fifo_read && fifo_q.size() == 0) underflow++;
    if (fifo_read) begin
      dut_pops++;
      pop_cyc.push_back(cyc);
    end
    if (req_valid && req_ready) begin
      xfers++;
      xfer_cyc.push_back(cyc);
    end
    if (reset && (buf_q.size() != 0) && !req_ready) exp_stalls++;
    if (exp_rd) exp_pop_cnt++;
    @(posedge clk);
    #1;
    if (exp_xf) buf_q.delete(0);
    if (exp_rd) buf_q.push_back(fifo_q.pop_front());
    cyc++;
    fifo_sync();
`ifdef PROJECT_REQ_DRAIN_STATS_EN
    chk("pop_count", pop_count, exp_pop_cnt);
    chk("stall_count", stall_count, exp_stalls);
`endif
  endtask

  task automatic do_reset();
    reset = 1'b0;
    fifo_q.delete();
    buf_q.delete();
    fifo_sync();
    exp_pop_cnt = '0;
    exp_stalls  = '0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int bp;
    int bx;
    int n;
    logic [W-1:0] first;

    // Reset with the FIFO non-empty and enable high: read strobe stays low.
    reset = 1'b0;
    enable = 1'b1;
    req_ready = 1'b1;
    fifo_q.push_back(W'(5));
    fifo_sync();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fifo_read", 32'(fifo_read), 32'd0);
    chk("rst_req_valid", 32'(req_valid), 32'd0);
    chk("rst_req_data", 32'(req_data), 32'd0);
`ifdef PROJECT_REQ_DRAIN_STATS_EN
    chk("rst_pop_count", pop_count, 32'd0);
    chk("rst_stall_count", stall_count, 32'd0);
`endif
    fifo_q.delete();
    fifo_sync();
    reset = 1'b1;

    // Four entries at full throughput.
    fifo_q = '{21'h1, 21'h2, 21'h3, 21'h4};
    fifo_sync();
    pop_cyc.delete();
    xfer_cyc.delete();
    bp = dut_pops;
    bx = xfers;
    repeat (7) tick();
    chk("t1_pops", 32'(dut_pops - bp), 32'd4);
    chk("t1_xfers", 32'(xfers - bx), 32'd4);
    chk("t1_nxfer", 32'(xfer_cyc.size()), 32'd4);
    if (xfer_cyc.size() == 4 && pop_cyc.size() != 0) begin
      chk("t1_latency", 32'(xfer_cyc[0] - pop_cyc[0]), 32'd1);
      chk("t1_back2back", 32'(xfer_cyc[3] - xfer_cyc[0]), 32'd3);
    end

    // Back-pressure with eight entries queued.
    req_ready = 1'b0;
    push_rand(8);
    first = fifo_q[0];
    bp = dut_pops;
    bx = xfers;
    repeat (6) tick();
    chk("bp_pops", 32'(dut_pops - bp), 32'd2);
    chk("bp_valid", 32'(req_valid), 32'd1);
    chk("bp_head", 32'(req_data), 32'(first));
    req_ready = 1'b1;
    repeat (12) tick();
    chk("bp_drain", 32'(xfers - bx), 32'd8);

    // Empty FIFO: no read strobes at all.
    bp = dut_pops;
    repeat (10) tick();
    chk("empty_pops", 32'(dut_pops - bp), 32'd0);
    chk("empty_underflow", 32'(underflow), 32'd0);

    // Enable dropped after three pops of a six-entry stream.
    push_rand(6);
    bp = dut_pops;
    bx = xfers;
    n = 0;
    while ((dut_pops - bp) < 3 && n < 20) begin
      tick();
      n++;
    end
    chk("en_first3", 32'(dut_pops - bp), 32'd3);
    enable = 1'b0;
    repeat (5) tick();
    chk("en_off_pops", 32'(dut_pops - bp), 32'd3);
    chk("en_off_xfers", 32'(xfers - bx), 32'd3);
    enable = 1'b1;
    repeat (8) tick();
    chk("en_on_pops", 32'(dut_pops - bp), 32'd6);
    chk("en_on_xfers", 32'(xfers - bx), 32'd6);

    // Asynchronous reset while both slots are full.
    req_ready = 1'b0;
    push_rand(4);
    repeat (3) tick();
    chk("two_valid", 32'(req_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(req_valid), 32'd0);
    chk("arst_fifo_read", 32'(fifo_read), 32'd0);
    fifo_q.delete();
    buf_q.delete();
    fifo_sync();
    exp_pop_cnt = '0;
    exp_stalls  = '0;
    repeat (2) tick();
    reset = 1'b1;
    req_ready = 1'b1;
    push_rand(3);
    bx = xfers;
    repeat (6) tick();
    chk("arst_resume", 32'(xfers - bx), 32'd3);

`ifdef PROJECT_REQ_DRAIN_STATS_EN
    // Five pops with seven stalled cycles.
    do_reset();
    req_ready = 1'b0;
    push_rand(5);
    repeat (8) tick();
    req_ready = 1'b1;
    repeat (8) tick();
    chk("stats_pops", pop_count, 32'd5);
    chk("stats_stalls", stall_count, 32'd7);
`endif

    // Randomized traffic, then drain; every pushed word must come out.
    do_reset();
    pushed = 0;
    bx = xfers;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 2) != 0) push_rand(1);
      req_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
      tick();
    end
    enable = 1'b1;
    req_ready = 1'b1;
    n = 0;
    while ((fifo_q.size() != 0 || buf_q.size() != 0) && n < 1000) begin
      tick();
      n++;
    end
    tick();
    chk("rand_all_out", 32'(xfers - bx), 32'(pushed));
    chk("no_underflow", 32'(underflow), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/project_req_drain.md
# project_req_drain

Read-side drain for the request FIFO (`fifo_improved_project_req`). It pops entries only when the FIFO is non-empty and the block has room, so it never underflows the FIFO's unguarded read pointer. Popped entries are held in a two-entry output buffer and presented downstream over a valid/ready handshake. It sits between the request FIFO and the PageRank request consumer, and gives full throughput without a combinational path from `req_ready` to `fifo_read`.

## Interface
- `WIDTH`, 21, request word width; matches the FIFO `WIDTH`.
- `clk`  input  1  single clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `enable`  input  1  when high, the block may pop the FIFO; when low, no new pops, but buffered entries still drain.
- `fifo_empty`  input  1  FIFO `empty` flag (registered in the FIFO).
- `fifo_data`  input  WIDTH  FIFO `dataOut`; valid in any cycle where `fifo_empty`=0 (combinational read at tail).
- `fifo_read`  output  1  FIFO `read` strobe; one entry is popped per cycle it is high.
- `req_valid`  output  1  a downstream request is available.
- `req_data`  output  WIDTH  request word; stable while `req_valid`=1 and `req_ready`=0.
- `req_ready`  input  1  downstream accepts; a transfer occurs when `req_valid` and `req_ready` are both 1.
- `pop_count`  output  32  (only with `PROJECT_REQ_DRAIN_STATS_EN`) total FIFO pops.
- `stall_count`  output  32  (only with `PROJECT_REQ_DRAIN_STATS_EN`) cycles with `req_valid`=1 and `req_ready`=0.

## Operation
- Occupancy state machine, states `EMPTY`, `ONE`, `TWO` (count of buffered entries). Slot0 is the head and drives `req_data`; slot1 is the skid slot.
- `fifo_read` = `enable` & ~`fifo_empty` & (state != `TWO`). It is combinational from registered or FIFO-registered signals only and never depends on `req_ready`.
- Let pop = `fifo_read` and xfer = `req_valid` & `req_ready`. Transitions:
  - `EMPTY`: pop → `ONE`.
  - `ONE`: pop & ~xfer → `TWO`; ~pop & xfer → `EMPTY`; otherwise stay.
  - `TWO`: xfer → `ONE`; otherwise stay.
- Data movement:
  - Pop into `EMPTY` writes slot0.
  - In `ONE`: pop & xfer writes slot0; pop & ~xfer writes slot1.
  - In `TWO`: xfer moves slot1 into slot0.
- `req_valid` = (state != `EMPTY`), registered. `req_data` = slot0, registered.
- Ordering is strict FIFO; no entry is dropped or duplicated.
- `fifo_read` is never asserted while `fifo_empty`=1. This is a hard requirement, because the FIFO tail increments unconditionally on `read`.

## Timing
- Reset (`reset`=0): state `EMPTY`, `req_valid`=0, `req_data`=0, slots=0, `fifo_read`=0 (forced low during reset), counters=0.
- Latency: `fifo_empty` low at cycle N with state `EMPTY` gives `fifo_read` high at N and `req_valid` with data at N+1.
- Throughput: one request per cycle with `req_ready` held high. Steady state is `ONE`, with pop and xfer together every cycle.
- Back-pressure: `req_ready` low for k cycles gives at most 2 pops, then `fifo_read`=0 until a transfer occurs.
- `enable` deasserted mid-stream: `fifo_read` drops in the same cycle; buffered entries still transfer.
- FIFO drains while state is `ONE`: `fifo_empty` high stops pops immediately; the buffered entry remains valid.
- Reset asserted mid-operation: buffered entries are discarded. The FIFO shares the same reset, so both sides restart empty.
- Counters wrap modulo 2^32.

## Configuration
- `PROJECT_REQ_DRAIN_STATS_EN` defined:
  - `pop_count` increments on each `fifo_read`.
  - `stall_count` increments on each cycle with `req_valid` & ~`req_ready`.
  - Both are registered and reset to 0.
- Not defined: the ports and counters are absent; all other behaviour is identical.

## Structure
- Package `project_req_pkg`:
  - state enum `drain_state_t` (`EMPTY`, `ONE`, `TWO`);
  - `REQ_WIDTH` = 21;
  - `STAT_WIDTH` = 32.
- Sub-module `project_req_skid2`: the two-slot buffer with its occupancy FSM. It takes `push`/`push_data`/`pop` and outputs `valid`/`data`/`space`, where `space` = (state != `TWO`). The top level adds the `fifo_read` gating, `enable`, and the stats counters.

## Test plan
- Reset, then FIFO loaded with 0x00001..0x00004, `req_ready`=1 → `req_data` shows 1,2,3,4 on consecutive cycles starting 1 cycle after the first `fifo_read`; exactly 4 pops.
- `req_ready`=0 with 8 entries queued → exactly 2 pops; `req_valid`=1 with `req_data`=first entry held stable; raising `req_ready` drains all 8 in order.
- FIFO empty for 10 cycles → `fifo_read`=0 throughout; the FIFO tail pointer is unchanged.
- `enable` dropped after 3 pops of a 6-entry stream → no further pops; the 3 buffered/transferred entries complete; re-enabling resumes with entry 4.
- Reset pulsed while in state `TWO` → `req_valid`=0 and `fifo_read`=0 immediately (asynchronously); after release, normal operation on fresh FIFO data.
- With `PROJECT_REQ_DRAIN_STATS_EN`: 5 pops and 7 back-pressure cycles → `pop_count`=5, `stall_count`=7.
